// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
//   Shared types and helpers for the systolic matrix-multiply engine.
//   - sa_state_t : engine control states IDLE -> LOAD -> FLUSH -> DRAIN
//   - clog2_min1 : $clog2 that never returns 0, so a 1-entry index still
//                  gets a 1-bit signal.
// ---------------------------------------------------------------------------
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } sa_state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_matmul_engine_mac_pe.sv
// ---------------------------------------------------------------------------
// mac_pe
//   One processing element of the output-stationary systolic array.
//   On every enabled step it forwards A to the right and B downward through
//   registers and accumulates the signed product a*b into its accumulator.
//
//   Configuration macro: SYSTOLIC_SATURATE_EN
//     defined   : each accumulate clamps to the signed ACC_W range and
//                 raises sat for that step
//     undefined : accumulation wraps modulo 2^ACC_W, sat is tied to 0
//
//   Ports
//     clk    in   clock, rising edge
//     rst    in   asynchronous active-low reset
//     en     in   advance enable (accepted beat or flush step)
//     clr    in   synchronous clear of accumulator and pass registers
//     a_in   in   A operand from the left neighbour / skew chain
//     b_in   in   B operand from the upper neighbour / skew chain
//     a_out  out  registered A for the right neighbour
//     b_out  out  registered B for the lower neighbour
//     acc    out  accumulator value
//     sat    out  this enabled step clamped (saturating build only)
// ---------------------------------------------------------------------------
module mac_pe
  import tpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_out,
  output logic signed [DATA_W-1:0] b_out,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     sat
);

  localparam int PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_nxt;

  // Operands are sign-extended first so the full-width product is exact.
  assign a_ext    = PROD_W'(a_in);
  assign b_ext    = PROD_W'(b_in);
  assign prod     = a_ext * b_ext;
  assign prod_ext = ACC_W'(prod);

`ifdef SYSTOLIC_SATURATE_EN
  logic signed [ACC_W:0] sum_wide;
  logic                  ovf;

  // One guard bit is enough: adding two ACC_W-bit signed values can only
  // overflow by one bit, visible as the top two bits disagreeing.
  assign sum_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(prod_ext);
  assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  // Clamp toward the side the true sum lies on.
  always_comb begin
    acc_nxt = sum_wide[ACC_W-1:0];
    if (ovf) begin
      acc_nxt = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign sat = en & ovf;
`else
  assign acc_nxt = acc + prod_ext;
  assign sat     = 1'b0;
`endif

  // Pass-through registers and accumulator only move on enabled steps, so
  // input bubbles freeze the whole wavefront in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc_nxt;
    end
  end

endmodule

// File: rtl/systolic_matmul_engine.sv
// ---------------------------------------------------------------------------
// systolic_matmul_engine
//   Output-stationary ROWS x COLS systolic engine computing C = A x B.
//   Each accepted beat carries one column of A (a_in) and one row of B
//   (b_in). Operand skewing, zero-injection flush and a row-serial result
//   drain are handled internally.
//
//   Configuration macro: SYSTOLIC_SATURATE_EN
//     defined   : saturating accumulation, sat_flag sticky per job
//     undefined : wrap-around accumulation, sat_flag tied to 0
//
//   Ports
//     clk          in   clock, rising edge
//     rst          in   asynchronous active-low reset
//     start        in   begin a job (sampled only in IDLE)
//     k_len        in   inner dimension, latched on start, clamped to K_MAX
//     in_valid     in   operand beat valid
//     in_ready     out  engine accepts a beat (LOAD only)
//     a_in         in   lane i = A[i][k]
//     b_in         in   lane j = B[k][j]
//     out_valid    out  result row valid (DRAIN)
//     out_ready    in   downstream accepts the row
//     out_row      out  lane j = C[out_row_idx][j]
//     out_row_idx  out  index of the presented row
//     busy         out  engine not idle
//     done         out  1-cycle pulse after the last row handshake
//     sat_flag     out  an accumulator saturated during this job
// ---------------------------------------------------------------------------
module systolic_matmul_engine
  import tpu_pkg::*;
#(
  parameter  int ROWS   = 4,
  parameter  int COLS   = 4,
  parameter  int DATA_W = 8,
  parameter  int ACC_W  = 32,
  parameter  int K_MAX  = 256,
  localparam int KW     = $clog2(K_MAX + 1),
  localparam int IDX_W  = clog2_min1(ROWS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_W-1:0]   a_in,
  input  logic [COLS*DATA_W-1:0]   b_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS*ACC_W-1:0]    out_row,
  output logic [IDX_W-1:0]         out_row_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_flag
);

  localparam int FLUSH_CYC = ROWS + COLS - 2;
  localparam int FW        = clog2_min1(ROWS + COLS);

  if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
    $error("systolic_matmul_engine: ACC_W must be at least 2*DATA_W");
  end

  sa_state_t      state;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  beat_cnt;
  logic [FW-1:0]  flush_cnt;
  logic [KW-1:0]  k_clamped;
  logic           beat_ok;
  logic           flushing;
  logic           adv;
  logic           clr;

  logic signed [DATA_W-1:0] a_h      [ROWS][COLS+1];
  logic signed [DATA_W-1:0] b_v      [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  acc_grid [ROWS][COLS];
  logic [ROWS*COLS-1:0]     sat_vec;

  assign k_clamped = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign beat_ok   = in_valid & in_ready;
  assign flushing  = (state == FLUSH);
  assign adv       = beat_ok | flushing;
  assign clr       = (state == IDLE) & start;

  // Control FSM. All handshake/status outputs are registered and are set
  // for the state being entered, so they line up with the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      k_q         <= '0;
      beat_cnt    <= '0;
      flush_cnt   <= '0;
      out_row_idx <= '0;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_q         <= k_clamped;
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            out_row_idx <= '0;
            busy        <= 1'b1;
            // An empty job has nothing to compute: results are the
            // freshly cleared accumulators.
            if (k_clamped == '0) begin
              state     <= DRAIN;
              out_valid <= 1'b1;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (beat_ok) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt == k_q - KW'(1)) begin
              in_ready <= 1'b0;
              if (FLUSH_CYC == 0) begin
                state     <= DRAIN;
                out_valid <= 1'b1;
              end else begin
                state <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + FW'(1);
          if (flush_cnt == FW'(FLUSH_CYC - 1)) begin
            state     <= DRAIN;
            out_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_row_idx == IDX_W'(ROWS - 1)) begin
              state       <= IDLE;
              out_valid   <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              out_row_idx <= '0;
            end else begin
              out_row_idx <= out_row_idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A skew: lane i passes through i enabled-step delay stages so that A[i][k]
  // meets B[k][j] at PE(i,j) on the same step. Zeros are injected in FLUSH.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    logic signed [DATA_W-1:0] lane;
    assign lane = flushing ? '0 : $signed(a_in[i*DATA_W +: DATA_W]);
    if (i == 0) begin : g_direct
      assign a_h[i][0] = lane;
    end else begin : g_delay
      logic signed [DATA_W-1:0] sr [i];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < i; s++) sr[s] <= '0;
        end else if (clr) begin
          for (int s = 0; s < i; s++) sr[s] <= '0;
        end else if (adv) begin
          sr[0] <= lane;
          for (int s = 1; s < i; s++) sr[s] <= sr[s-1];
        end
      end
      assign a_h[i][0] = sr[i-1];
    end
  end

  // B skew: lane j delayed j enabled steps, mirroring the A side.
  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    logic signed [DATA_W-1:0] lane;
    assign lane = flushing ? '0 : $signed(b_in[j*DATA_W +: DATA_W]);
    if (j == 0) begin : g_direct
      assign b_v[0][j] = lane;
    end else begin : g_delay
      logic signed [DATA_W-1:0] sr [j];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < j; s++) sr[s] <= '0;
        end else if (clr) begin
          for (int s = 0; s < j; s++) sr[s] <= '0;
        end else if (adv) begin
          sr[0] <= lane;
          for (int s = 1; s < j; s++) sr[s] <= sr[s-1];
        end
      end
      assign b_v[0][j] = sr[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .en    (adv),
        .clr   (clr),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_h[i][j+1]),
        .b_out (b_v[i+1][j]),
        .acc   (acc_grid[i][j]),
        .sat   (sat_vec[i*COLS+j])
      );
    end
  end

  // Operands leaving the right and bottom edges of the array go nowhere.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_edge
    logic unused_a;
    assign unused_a = ^a_h[i][COLS];
  end
  for (genvar j = 0; j < COLS; j++) begin : g_b_edge
    logic unused_b;
    assign unused_b = ^b_v[ROWS][j];
  end

  // Row-select mux. Accumulators are frozen in DRAIN, so the presented row
  // stays stable while downstream applies backpressure.
  always_comb begin
    out_row = '0;
    for (int j = 0; j < COLS; j++) begin
      out_row[j*ACC_W +: ACC_W] = acc_grid[out_row_idx][j];
    end
  end

`ifdef SYSTOLIC_SATURATE_EN
  // Sticky per job: cleared when a new job starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag <= 1'b0;
    end else if (clr) begin
      sat_flag <= 1'b0;
    end else if (|sat_vec) begin
      sat_flag <= 1'b1;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = |sat_vec;
  assign sat_flag   = 1'b0;
`endif

endmodule
